// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU constants, state encodings and helpers
package alu_pkg;

    localparam int ALU_DEFAULT_WIDTH = 8;
    localparam int ALU_DEFAULT_DIGIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

    // Counter must hold 0..n-1 and never collapse to zero width.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/full_sub_1bit.sv
// rtl/full_sub_1bit.sv - one-bit full subtractor from two half subtractors
module full_sub_1bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    assign d1   = a ^ b;
    assign b1   = ~a & b;
    assign d    = d1 ^ bin;
    assign b2   = ~d1 & bin;
    assign bout = b1 | b2;

endmodule

// File: rtl/serial_sub_nbit.sv
// rtl/serial_sub_nbit.sv - digit-serial subtractor a - b - bin with flags
module serial_sub_nbit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_DEFAULT_WIDTH,
    parameter int DIGIT = ALU_DEFAULT_DIGIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = cnt_width(N);

    generate
        if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
            $error("serial_sub_nbit: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    alu_state_t state;
    alu_state_t state_nx;

    logic [CNT_W-1:0]       cnt;
    logic [WIDTH-1:0]       a_sh;
    logic [WIDTH-1:0]       b_sh;
    logic [WIDTH-1:0]       r_sh;
    logic                   brw_q;
    logic                   a_msb;
    logic                   b_msb;
    logic                   accept;
    logic                   last;
    logic [DIGIT:0]         chain;
    logic [DIGIT-1:0]       slice;
    logic [WIDTH+DIGIT-1:0] r_cat;
    logic [WIDTH-1:0]       r_nx;

    assign accept = start && (state != ST_RUN);
    assign last   = (cnt == CNT_W'(N - 1));
    assign busy   = (state == ST_RUN);
    assign done   = (state == ST_DONE);

    assign chain[0] = brw_q;

    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_cell
            full_sub_1bit u_cell (
                .a    (a_sh[i]),
                .b    (b_sh[i]),
                .bin  (chain[i]),
                .d    (slice[i]),
                .bout (chain[i+1])
            );
        end
    endgenerate

    // New slice enters at the top; after N cycles the LSB slice sits at bit 0.
    assign r_cat = {slice, r_sh};
    assign r_nx  = r_cat[WIDTH+DIGIT-1:DIGIT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_RUN;
            ST_RUN:  if (last)  state_nx = ST_DONE;
            ST_DONE: state_nx = start ? ST_RUN : ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            brw_q <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            d     <= '0;
            bout  <= 1'b0;
            zero  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            a_sh  <= a;
            b_sh  <= b;
            r_sh  <= '0;
            brw_q <= bin;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (state == ST_RUN) begin
            a_sh  <= a_sh >> DIGIT;
            b_sh  <= b_sh >> DIGIT;
            r_sh  <= r_nx;
            brw_q <= chain[DIGIT];
            if (!last) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                d    <= r_nx;
                bout <= chain[DIGIT];
                zero <= (r_nx == '0);
                ovf  <= (a_msb != b_msb) && (r_nx[WIDTH-1] != a_msb);
            end
        end
    end

endmodule

// File: tb/tb_serial_sub_nbit.sv
// tb/tb_serial_sub_nbit.sv - scoreboard bench over DIGIT = 1, 2, 4, 8
module tb_serial_sub_nbit;

    typedef struct {
        int         k;
        logic [7:0] d;
        logic       bout;
        logic       zero;
        logic       ovf;
        int         cyc;
    } exp_t;

    localparam int NCYC [4] = '{8, 4, 2, 1};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a_i;
    logic [7:0] b_i;
    logic       bin_i;
    logic [3:0] start_v;
    logic [3:0] busy_v;
    logic [3:0] done_v;
    logic [3:0] bout_v;
    logic [3:0] zero_v;
    logic [3:0] ovf_v;
    logic [7:0] d_v [4];

    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    exp_t mon_e;
    exp_t tmp_e;
    int   t0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_sub_nbit #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_i), .b(b_i), .bin(bin_i),
        .busy(busy_v[0]), .done(done_v[0]), .d(d_v[0]), .bout(bout_v[0]), .zero(zero_v[0]), .ovf(ovf_v[0]));
    serial_sub_nbit #(.WIDTH(8), .DIGIT(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_i), .b(b_i), .bin(bin_i),
        .busy(busy_v[1]), .done(done_v[1]), .d(d_v[1]), .bout(bout_v[1]), .zero(zero_v[1]), .ovf(ovf_v[1]));
    serial_sub_nbit #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_i), .b(b_i), .bin(bin_i),
        .busy(busy_v[2]), .done(done_v[2]), .d(d_v[2]), .bout(bout_v[2]), .zero(zero_v[2]), .ovf(ovf_v[2]));
    serial_sub_nbit #(.WIDTH(8), .DIGIT(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .a(a_i), .b(b_i), .bin(bin_i),
        .busy(busy_v[3]), .done(done_v[3]), .d(d_v[3]), .bout(bout_v[3]), .zero(zero_v[3]), .ovf(ovf_v[3]));

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int k, input logic [7:0] a, input logic [7:0] b,
                                   input logic bin, input int done_cyc);
        exp_t       e;
        logic [8:0] t;
        t      = {1'b0, a} - {1'b0, b} - {8'd0, bin};
        e.k    = k;
        e.d    = t[7:0];
        e.bout = t[8];
        e.zero = (t[7:0] == 8'd0);
        e.ovf  = (a[7] != b[7]) && (t[7] != a[7]);
        e.cyc  = done_cyc;
        return e;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (done_v[k]) begin
                if (sb.size() == 0) begin
                    expect_eq("spurious_done", 32'(done_v), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    expect_eq("done_dut",     32'(k),         32'(mon_e.k));
                    expect_eq("done_latency", 32'(cyc),       32'(mon_e.cyc));
                    expect_eq("d",            32'(d_v[k]),    32'(mon_e.d));
                    expect_eq("bout",         32'(bout_v[k]), 32'(mon_e.bout));
                    expect_eq("zero",         32'(zero_v[k]), 32'(mon_e.zero));
                    expect_eq("ovf",          32'(ovf_v[k]),  32'(mon_e.ovf));
                    expect_eq("busy_in_done", 32'(busy_v[k]), 32'd0);
                end
            end
        end
    end

    task automatic issue(input int k, input logic [7:0] a, input logic [7:0] b, input logic bin);
        a_i        = a;
        b_i        = b;
        bin_i      = bin;
        start_v[k] = 1'b1;
        sb.push_back(model(k, a, b, bin, cyc + 1 + NCYC[k]));
        @(negedge clk);
        start_v[k] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            expect_eq("timeout_pending", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic op(input int k, input logic [7:0] a, input logic [7:0] b, input logic bin);
        issue(k, a, b, bin);
        drain();
    endtask

    initial begin
        rst_n   = 1'b0;
        start_v = 4'd0;
        a_i     = 8'd0;
        b_i     = 8'd0;
        bin_i   = 1'b0;
        repeat (2) @(negedge clk);
        expect_eq("rst_busy", 32'(busy_v), 32'd0);
        expect_eq("rst_done", 32'(done_v), 32'd0);
        expect_eq("rst_flags", {20'd0, bout_v, zero_v, ovf_v}, 32'd0);
        for (int k = 0; k < 4; k++) expect_eq("rst_d", 32'(d_v[k]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        op(0, 8'h05, 8'h03, 1'b0);
        op(0, 8'h03, 8'h05, 1'b0);
        op(0, 8'h10, 8'h10, 1'b0);
        op(2, 8'h80, 8'h01, 1'b0);
        op(2, 8'h00, 8'h00, 1'b1);
        op(3, 8'h7F, 8'hFF, 1'b0);
        op(1, 8'h00, 8'hFF, 1'b1);

        // Second start mid-RUN must be ignored.
        issue(0, 8'h5A, 8'h33, 1'b0);
        repeat (3) @(negedge clk);
        expect_eq("busy_mid_run", 32'(busy_v[0]), 32'd1);
        a_i        = 8'hFF;
        b_i        = 8'h01;
        bin_i      = 1'b1;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        drain();

        // Start held through DONE: second op follows with no IDLE cycle.
        a_i        = 8'h20;
        b_i        = 8'h05;
        bin_i      = 1'b0;
        start_v[2] = 1'b1;
        t0         = cyc + 1;
        sb.push_back(model(2, 8'h20, 8'h05, 1'b0, t0 + 2));
        @(negedge clk);
        a_i   = 8'h07;
        b_i   = 8'h09;
        bin_i = 1'b1;
        sb.push_back(model(2, 8'h07, 8'h09, 1'b1, t0 + 5));
        repeat (2) @(negedge clk);
        @(negedge clk);
        start_v[2] = 1'b0;
        drain();

        // Reset during RUN aborts without a done pulse.
        issue(0, 8'h44, 8'h11, 1'b0);
        repeat (3) @(negedge clk);
        expect_eq("busy_before_rst", 32'(busy_v[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        expect_eq("abort_busy",  32'(busy_v[0]), 32'd0);
        expect_eq("abort_done",  32'(done_v[0]), 32'd0);
        expect_eq("abort_d",     32'(d_v[0]),    32'd0);
        expect_eq("abort_flags", {29'd0, bout_v[0], zero_v[0], ovf_v[0]}, 32'd0);
        tmp_e = sb.pop_back();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        op(0, 8'h44, 8'h11, 1'b0);

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 15; i++) begin
                op(k, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
